// File: rtl/fc_dot192.sv
// Single-neuron fully-connected classifier stage.
// Streams 192 int8 weights into a local RAM, then reduces 6-wide activation beats to one int32 result.
module fc_dot192 #(
    parameter int N_IN  = 192,
    parameter int LANES = 6,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ivalid,
    input  logic [DW-1:0]    din_0,
    input  logic [DW-1:0]    din_1,
    input  logic [DW-1:0]    din_2,
    input  logic [DW-1:0]    din_3,
    input  logic [DW-1:0]    din_4,
    input  logic [DW-1:0]    din_5,
    input  logic [DW-1:0]    weight,
    input  logic             weight_en,
    output logic             ovalid,
    output logic [ACC_W-1:0] dout
);

    localparam int NB = N_IN / LANES;
    localparam int BW = $clog2(NB);
    localparam int AW = $clog2(N_IN);
    localparam int PW = 2 * DW;
    localparam int SW = PW + 3;

    logic signed [DW-1:0] ram_q [N_IN];
    logic signed [DW-1:0] din [LANES];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          loaded_q, loaded_d;
    logic          wen_q, wen_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    logic          accept;
    logic [AW-1:0] base;
    logic [BW-1:0] beat_q, beat_d;

    logic signed [PW-1:0] prod_q [LANES];
    logic signed [PW-1:0] prod_d [LANES];
    logic                 v1_q, v1_d;
    logic                 last1_q, last1_d;

    logic signed [SW-1:0] sum_q, sum_d;
    logic                 v2_q, v2_d;
    logic                 last2_q, last2_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] dout_q, dout_d;
    logic signed [ACC_W-1:0] total;
    logic                    ovalid_q, ovalid_d;

    assign din[0] = din_0;
    assign din[1] = din_1;
    assign din[2] = din_2;
    assign din[3] = din_3;
    assign din[4] = din_4;
    assign din[5] = din_5;

    // A rising weight_en while loaded restarts the load at address 0.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        loaded_d = loaded_q;
        wen_d    = weight_en;
        if (!loaded_q && weight_en) begin
            wr_en = 1'b1;
        end else if (loaded_q && weight_en && !wen_q) begin
            wr_en   = 1'b1;
            wr_addr = '0;
        end
        if (wr_en) begin
            if (wr_addr == AW'(N_IN - 1)) begin
                loaded_d = 1'b1;
                wr_ptr_d = '0;
            end else begin
                loaded_d = 1'b0;
                wr_ptr_d = wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[wr_addr] <= weight;
        end
    end

    always_comb begin
        accept  = ivalid && loaded_q;
        base    = AW'(beat_q) * AW'(LANES);
        v1_d    = accept;
        last1_d = accept && (beat_q == BW'(NB - 1));
        beat_d  = beat_q;
        if (accept) begin
            beat_d = last1_d ? '0 : beat_q + 1'b1;
        end
        for (int k = 0; k < LANES; k++) begin
            prod_d[k] = PW'(din[k]) * PW'(ram_q[base + AW'(k)]);
        end
    end

    always_comb begin
        sum_d   = '0;
        v2_d    = v1_q;
        last2_d = last1_q;
        for (int k = 0; k < LANES; k++) begin
            sum_d = sum_d + SW'(prod_q[k]);
        end
    end

    // Final stage: accumulate, or emit and clear on the frame's last beat.
    always_comb begin
        total    = acc_q + ACC_W'(sum_q);
        acc_d    = acc_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        if (v2_q) begin
            if (last2_q) begin
                dout_d   = total;
                ovalid_d = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = total;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr_q <= '0;
            loaded_q <= 1'b0;
            wen_q    <= 1'b0;
            beat_q   <= '0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
            end
            sum_q    <= '0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            acc_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            loaded_q <= loaded_d;
            wen_q    <= wen_d;
            beat_q   <= beat_d;
            v1_q     <= v1_d;
            last1_q  <= last1_d;
            for (int k = 0; k < LANES; k++) begin
                prod_q[k] <= prod_d[k];
            end
            sum_q    <= sum_d;
            v2_q     <= v2_d;
            last2_q  <= last2_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign ovalid = ovalid_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_fc_dot192.sv
// Randomised bench for fc_dot192 against a plain dot-product model.
module tb_fc_dot192;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ivalid;
    logic        weight_en;
    logic [7:0]  weight;
    logic [7:0]  din [6];
    logic        ovalid;
    logic [31:0] dout;

    fc_dot192 dut (
        .clk       (clk),
        .rstn      (rstn),
        .ivalid    (ivalid),
        .din_0     (din[0]),
        .din_1     (din[1]),
        .din_2     (din[2]),
        .din_3     (din[3]),
        .din_4     (din[4]),
        .din_5     (din[5]),
        .weight    (weight),
        .weight_en (weight_en),
        .ovalid    (ovalid),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t expq [$];
    exp_t e;
    int   wts [192];
    int   wm  [192];
    int   act [192];
    bit   garble = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dot();
        int s = 0;
        for (int i = 0; i < 192; i++) s += wm[i] * act[i];
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        if (ovalid === 1'b1) begin
            if (expq.size() == 0) begin
                check("spurious_ovalid", 1, 0);
            end else begin
                e = expq.pop_front();
                check("dout", dout, e.val);
                check("latency", cyc, e.at);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ivalid = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn      = 1'b1;
        ivalid    = 1'b0;
        weight_en = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic load(input bit with_iv, input bit keep);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            weight_en = 1'b1;
            weight    = wts[i][7:0];
            ivalid    = with_iv;
            for (int k = 0; k < 6; k++) din[k] = 8'($urandom);
        end
        wm = wts;
        if (!keep) begin
            @(negedge clk);
            weight_en = 1'b0;
            ivalid    = 1'b0;
        end
    endtask

    task automatic send_frame(input int gap, input int nbeats);
        int g;
        for (int b = 0; b < nbeats; b++) begin
            g = (gap < 0) ? $urandom_range(3) : gap;
            repeat (g) begin
                @(negedge clk);
                ivalid = 1'b0;
            end
            @(negedge clk);
            ivalid = 1'b1;
            for (int k = 0; k < 6; k++) din[k] = act[b*6+k][7:0];
            if (garble) weight = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (nbeats == 32) begin
            e.val = dot();
            e.at  = cyc + 2;
            expq.push_back(e);
        end
    endtask

    initial begin
        rstn      = 1'b1;
        ivalid    = 1'b0;
        weight_en = 1'b0;
        weight    = '0;
        for (int k = 0; k < 6; k++) din[k] = '0;
        @(posedge clk);
        #1;
        check("rst_ovalid", ovalid, 0);
        check("rst_dout", dout, 0);
        @(negedge clk);
        rstn = 1'b0;

        foreach (wts[i]) wts[i] = 1;
        load(1'b1, 1'b0);
        idle(3);
        foreach (act[i]) act[i] = 1;
        send_frame(1, 32);
        idle(4);

        foreach (act[i]) act[i] = i % 6 + 1;
        send_frame(0, 32);
        idle(4);

        foreach (wts[i]) wts[i] = -128;
        load(1'b0, 1'b0);
        foreach (act[i]) act[i] = -128;
        send_frame(0, 32);
        idle(4);
        foreach (wts[i]) wts[i] = 127;
        load(1'b0, 1'b0);
        send_frame(-1, 32);
        idle(4);

        foreach (wts[i]) wts[i] = i - 96;
        load(1'b0, 1'b0);
        foreach (act[i]) act[i] = 1;
        send_frame(0, 32);
        foreach (act[i]) act[i] = 2;
        send_frame(0, 32);
        idle(4);

        send_frame(0, 11);
        reset_dut();
        idle(4);
        foreach (wts[i]) wts[i] = 1;
        load(1'b0, 1'b0);
        foreach (act[i]) act[i] = 1;
        send_frame(0, 32);
        idle(4);

        load(1'b0, 1'b1);
        garble = 1'b1;
        for (int f = 0; f < 2; f++) begin
            foreach (act[i]) act[i] = $urandom_range(255) - 128;
            send_frame(0, 32);
        end
        garble = 1'b0;
        @(negedge clk);
        weight_en = 1'b0;
        ivalid    = 1'b0;
        foreach (wts[i]) wts[i] = 2;
        load(1'b0, 1'b0);
        foreach (act[i]) act[i] = 1;
        send_frame(0, 32);
        idle(4);

        for (int r = 0; r < 4; r++) begin
            foreach (wts[i]) wts[i] = $urandom_range(255) - 128;
            load(1'b0, 1'b0);
            for (int f = 0; f < 2; f++) begin
                foreach (act[i]) act[i] = $urandom_range(255) - 128;
                send_frame((r % 2 == 0) ? -1 : 0, 32);
            end
            idle(2);
        end

        idle(10);
        check("pending", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
